ikaopm_timer_hostif: RTL and testbench
======================================

Name: ikaopm_timer_hostif

Overview:
- Host-side writer/reader for the timer block.
- Decodes 8-bit CPU bus writes (address latch on A0=0, data write on A0=1) into the timer control registers: CLKA1, CLKA2, CLKB, run, IRQ enable, flag reset, CSM and test bit D2.
- Returns the status byte (BUSY, FLAG_B, FLAG_A) on reads.
- Sits between the chip bus pins and the timer; drives every timer control input and consumes its flags.

Parameters:
- BUSY_CYCLES, 32: phi1 cycles BUSY stays asserted after a data write.
- BUSY_W, 6: width of the busy down-counter; must hold BUSY_CYCLES.

Ports:
- i_EMUCLK  in  1  emulator master clock; all state on its posedge.
- i_MRST  in  1  asynchronous active-high reset.
- i_phi1_NCEN_n  in  1  phi1 negative-edge clock enable, active low.
- i_CS_n  in  1  chip select, active low.
- i_WR_n  in  1  write strobe, active low.
- i_RD_n  in  1  read strobe, active low.
- i_A0  in  1  0 = address port, 1 = data/status port.
- i_D  in  8  write data.
- i_TIMERA_FLAG  in  1  flag from timer.
- i_TIMERB_FLAG  in  1  flag from timer.
- o_D  out  8  read data.
- o_D_OE  out  1  read data output enable.
- o_CLKA1  out  8  timer A high 8 bits (reg 0x10).
- o_CLKA2  out  2  timer A low 2 bits (reg 0x11[1:0]).
- o_CLKB  out  8  timer B value (reg 0x12).
- o_TIMERA_RUN  out  1  reg 0x14[0].
- o_TIMERB_RUN  out  1  reg 0x14[1].
- o_TIMERA_IRQ_EN  out  1  reg 0x14[2].
- o_TIMERB_IRQ_EN  out  1  reg 0x14[3].
- o_TIMERA_FRST  out  1  flag-reset pulse from 0x14[4].
- o_TIMERB_FRST  out  1  flag-reset pulse from 0x14[5].
- o_CSM  out  1  reg 0x14[7].
- o_TEST_D2  out  1  reg 0x01[2].
- o_BUSY  out  1  write-busy status.

Behaviour:
- Reset (async, i_MRST=1): every register and output is 0; address latch is 0x00; busy counter is 0; o_D=0x00; o_D_OE=0.
- Write strobe: wr = ~i_CS_n & ~i_WR_n, registered once.
  - The commit happens on the EMUCLK edge where the registered wr goes 1→0 (strobe trailing edge).
  - i_A0 and i_D are captured every EMUCLK while wr=1; the last captured values are used at commit.
  - Commit with A0=0: address latch <= D. No busy change.
  - Commit with A0=1: write D to the register selected by the address latch. The address latch persists, so repeated data writes go to the same register.
- Busy:
  - Every A0=1 commit loads the counter with BUSY_CYCLES, even if already busy (reload, data is still accepted).
  - The counter decrements on each EMUCLK with i_phi1_NCEN_n=0 while nonzero.
  - o_BUSY = (counter != 0), registered.
- Register map:
  - 0x01: bit2 → TEST_D2.
  - 0x10: CLKA1.
  - 0x11: bits[1:0] → CLKA2.
  - 0x12: CLKB.
  - 0x14: bits 7, 3, 2, 1, 0 are stored; bits 6 and 5/4 are not stored.
  - Other addresses are ignored.
  - Outputs change the EMUCLK after commit.
- FRST pulses:
  - A 0x14 commit with bit4 (bit5) = 1 sets o_TIMERA_FRST (o_TIMERB_FRST).
  - The pulse clears on the first EMUCLK with i_phi1_NCEN_n=0 strictly after it was set, so it is visible to exactly one phi1 sample.
  - A second set before the clear extends the pulse to that same clear point; no queueing.
  - Commit and clear on the same edge: set wins.
- Read:
  - o_D_OE <= ~i_CS_n & ~i_RD_n, registered.
  - o_D <= {o_BUSY, 5'b0, i_TIMERB_FLAG, i_TIMERA_FLAG} for any A0, registered every EMUCLK.
  - Simultaneous RD and WR: the write decodes normally and the read returns status.
- Reset mid-write: the strobe history is cleared, so no commit occurs on the following release.

Optional Feature:
- Macro: IKAOPM_TIMER_REGREAD_EN.
- Defined: a read with A0=0 returns the register at the address latch. Sources: 0x10 CLKA1, 0x11 {6'b0, CLKA2}, 0x12 CLKB, 0x14 {CSM, 3'b0, IRQEN_B, IRQEN_A, RUN_B, RUN_A}, 0x01 {5'b0, TEST_D2, 2'b0}, others 0x00. A read with A0=1 returns status.
- Undefined: every read returns status regardless of A0; no readback muxing is synthesized.

Test Plan:
- Reset, then write addr 0x10 / data 0xA5, addr 0x11 / data 0xFF, addr 0x12 / data 0x3C → o_CLKA1=0xA5, o_CLKA2=2'b11, o_CLKB=0x3C.
- Write 0x14 / data 0x8F → RUN_A=RUN_B=IRQEN_A=IRQEN_B=CSM=1. Then write 0x14 / data 0x30 → both FRST high for exactly one NCEN sample; run, IRQ enable and CSM all now 0.
- Data write, then count NCEN enables → o_BUSY high for exactly 32 enables, then 0. A second data write at count 10 → busy lasts 32 more enables from the reload.
- Drive i_TIMERA_FLAG=1, i_TIMERB_FLAG=0 during busy and read → o_D=0x81, o_D_OE=1 one EMUCLK after RD/CS assert.
- Assert i_MRST in the middle of a WR strobe, then release strobe → no register change, all outputs 0.
- With IKAOPM_TIMER_REGREAD_EN: after writing 0x12=0x3C, read with A0=0 → o_D=0x3C. Without the macro → o_D is status.

Source files
------------

// File: rtl/ikaopm_timer_hostif.sv
// ikaopm_timer_hostif
//   Host bus front end for the timer block. Decodes 8-bit CPU writes
//   (address port on A0=0, data port on A0=1) into the timer control
//   registers. It also returns the status byte {BUSY, 5'b0, FLAG_B, FLAG_A}
//   on reads.
//
// Ports
//   i_EMUCLK        master clock, all state on posedge
//   i_MRST          asynchronous active-high reset
//   i_phi1_NCEN_n   phi1 clock enable (active low)
//   i_CS_n/i_WR_n/i_RD_n/i_A0/i_D   CPU bus
//   i_TIMERA_FLAG/i_TIMERB_FLAG     flags from the timer
//   o_D/o_D_OE      read data and its output enable
//   o_CLKA1/o_CLKA2/o_CLKB          timer reload values
//   o_TIMERx_RUN/o_TIMERx_IRQ_EN    timer control bits
//   o_TIMERx_FRST   single-phi1 flag-reset pulses
//   o_CSM/o_TEST_D2 misc control bits
//   o_BUSY          write-busy status
//
// Optional feature macro: IKAOPM_TIMER_REGREAD_EN
//   When defined, a read with A0=0 returns the register selected by the
//   address latch. When undefined, every read returns status.

module ikaopm_timer_hostif #(
    parameter int BUSY_CYCLES = 32,
    parameter int BUSY_W      = 6
) (
    input  logic       i_EMUCLK,
    input  logic       i_MRST,
    input  logic       i_phi1_NCEN_n,
    input  logic       i_CS_n,
    input  logic       i_WR_n,
    input  logic       i_RD_n,
    input  logic       i_A0,
    input  logic [7:0] i_D,
    input  logic       i_TIMERA_FLAG,
    input  logic       i_TIMERB_FLAG,
    output logic [7:0] o_D,
    output logic       o_D_OE,
    output logic [7:0] o_CLKA1,
    output logic [1:0] o_CLKA2,
    output logic [7:0] o_CLKB,
    output logic       o_TIMERA_RUN,
    output logic       o_TIMERB_RUN,
    output logic       o_TIMERA_IRQ_EN,
    output logic       o_TIMERB_IRQ_EN,
    output logic       o_TIMERA_FRST,
    output logic       o_TIMERB_FRST,
    output logic       o_CSM,
    output logic       o_TEST_D2,
    output logic       o_BUSY
);

    localparam logic [BUSY_W-1:0] BUSY_LOAD = BUSY_W'(BUSY_CYCLES);

    logic              w_wr;
    logic              w_phi1;
    logic              w_commit;
    logic              w_commit_addr;
    logic              w_commit_data;
    logic [7:0]        w_status;
    logic [7:0]        w_rdata;

    logic              r_wr;
    logic              r_wr_armed;
    logic              r_a0;
    logic [7:0]        r_d;
    logic [7:0]        r_addr;
    logic [BUSY_W-1:0] r_busy_cnt;

    assign w_wr          = ~i_CS_n & ~i_WR_n;
    assign w_phi1        = ~i_phi1_NCEN_n;
    // Commit on the trailing edge of the registered strobe.
    assign w_commit      = r_wr & ~w_wr;
    assign w_commit_addr = w_commit & ~r_a0;
    assign w_commit_data = w_commit &  r_a0;
    assign w_status      = {o_BUSY, 5'b0, i_TIMERB_FLAG, i_TIMERA_FLAG};

    // Strobe tracking and bus capture. The armed flag needs one idle bus
    // cycle after reset, so a strobe that straddles reset never commits.
    always_ff @(posedge i_EMUCLK or posedge i_MRST) begin
        if (i_MRST) begin
            r_wr_armed <= 1'b0;
            r_wr       <= 1'b0;
            r_a0       <= 1'b0;
            r_d        <= 8'h00;
            r_addr     <= 8'h00;
        end else begin
            r_wr_armed <= r_wr_armed | ~w_wr;
            r_wr       <= w_wr & r_wr_armed;
            if (w_wr) begin
                r_a0 <= i_A0;
                r_d  <= i_D;
            end
            if (w_commit_addr)
                r_addr <= r_d;
        end
    end

    // Register file.
    always_ff @(posedge i_EMUCLK or posedge i_MRST) begin
        if (i_MRST) begin
            o_CLKA1         <= 8'h00;
            o_CLKA2         <= 2'b00;
            o_CLKB          <= 8'h00;
            o_TIMERA_RUN    <= 1'b0;
            o_TIMERB_RUN    <= 1'b0;
            o_TIMERA_IRQ_EN <= 1'b0;
            o_TIMERB_IRQ_EN <= 1'b0;
            o_CSM           <= 1'b0;
            o_TEST_D2       <= 1'b0;
        end else if (w_commit_data) begin
            case (r_addr)
                8'h01: o_TEST_D2 <= r_d[2];
                8'h10: o_CLKA1   <= r_d;
                8'h11: o_CLKA2   <= r_d[1:0];
                8'h12: o_CLKB    <= r_d;
                8'h14: begin
                    o_TIMERA_RUN    <= r_d[0];
                    o_TIMERB_RUN    <= r_d[1];
                    o_TIMERA_IRQ_EN <= r_d[2];
                    o_TIMERB_IRQ_EN <= r_d[3];
                    o_CSM           <= r_d[7];
                end
                default: ;
            endcase
        end
    end

    // Flag-reset pulses: set wins over clear, so a pulse set on a phi1 edge
    // survives until the next phi1 edge and is seen by exactly one sample.
    always_ff @(posedge i_EMUCLK or posedge i_MRST) begin
        if (i_MRST) begin
            o_TIMERA_FRST <= 1'b0;
            o_TIMERB_FRST <= 1'b0;
        end else begin
            if (w_commit_data && r_addr == 8'h14 && r_d[4])
                o_TIMERA_FRST <= 1'b1;
            else if (w_phi1)
                o_TIMERA_FRST <= 1'b0;

            if (w_commit_data && r_addr == 8'h14 && r_d[5])
                o_TIMERB_FRST <= 1'b1;
            else if (w_phi1)
                o_TIMERB_FRST <= 1'b0;
        end
    end

    // Busy down-counter; a data write reloads even while already busy.
    always_ff @(posedge i_EMUCLK or posedge i_MRST) begin
        if (i_MRST) begin
            r_busy_cnt <= '0;
            o_BUSY     <= 1'b0;
        end else begin
            if (w_commit_data)
                r_busy_cnt <= BUSY_LOAD;
            else if (w_phi1 && r_busy_cnt != '0)
                r_busy_cnt <= r_busy_cnt - 1'b1;
            o_BUSY <= (r_busy_cnt != '0);
        end
    end

`ifdef IKAOPM_TIMER_REGREAD_EN
    logic [7:0] w_regrd;

    always_comb begin
        w_regrd = 8'h00;
        case (r_addr)
            8'h01: w_regrd = {5'b0, o_TEST_D2, 2'b0};
            8'h10: w_regrd = o_CLKA1;
            8'h11: w_regrd = {6'b0, o_CLKA2};
            8'h12: w_regrd = o_CLKB;
            8'h14: w_regrd = {o_CSM, 3'b0, o_TIMERB_IRQ_EN, o_TIMERA_IRQ_EN,
                              o_TIMERB_RUN, o_TIMERA_RUN};
            default: w_regrd = 8'h00;
        endcase
    end

    assign w_rdata = i_A0 ? w_status : w_regrd;
`else
    assign w_rdata = w_status;
`endif

    // Read path.
    always_ff @(posedge i_EMUCLK or posedge i_MRST) begin
        if (i_MRST) begin
            o_D    <= 8'h00;
            o_D_OE <= 1'b0;
        end else begin
            o_D    <= w_rdata;
            o_D_OE <= ~i_CS_n & ~i_RD_n;
        end
    end

endmodule

// File: tb/tb_ikaopm_timer_hostif.sv
module tb_ikaopm_timer_hostif;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ncen_n = 1'b1;
    logic       cs_n = 1'b1;
    logic       wr_n = 1'b1;
    logic       rd_n = 1'b1;
    logic       a0 = 1'b0;
    logic [7:0] d = 8'h00;
    logic       fa = 1'b0;
    logic       fb = 1'b0;

    logic [7:0] o_d;
    logic       o_d_oe;
    logic [7:0] clka1;
    logic [1:0] clka2;
    logic [7:0] clkb;
    logic       run_a, run_b, irq_a, irq_b, frst_a, frst_b, csm, test_d2, busy;

    int n_cmp = 0;
    int n_err = 0;

    ikaopm_timer_hostif dut (
        .i_EMUCLK        (clk),
        .i_MRST          (rst),
        .i_phi1_NCEN_n   (ncen_n),
        .i_CS_n          (cs_n),
        .i_WR_n          (wr_n),
        .i_RD_n          (rd_n),
        .i_A0            (a0),
        .i_D             (d),
        .i_TIMERA_FLAG   (fa),
        .i_TIMERB_FLAG   (fb),
        .o_D             (o_d),
        .o_D_OE          (o_d_oe),
        .o_CLKA1         (clka1),
        .o_CLKA2         (clka2),
        .o_CLKB          (clkb),
        .o_TIMERA_RUN    (run_a),
        .o_TIMERB_RUN    (run_b),
        .o_TIMERA_IRQ_EN (irq_a),
        .o_TIMERB_IRQ_EN (irq_b),
        .o_TIMERA_FRST   (frst_a),
        .o_TIMERB_FRST   (frst_b),
        .o_CSM           (csm),
        .o_TEST_D2       (test_d2),
        .o_BUSY          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic a, input logic [7:0] v);
        @(negedge clk);
        a0 = a; d = v; cs_n = 1'b0; wr_n = 1'b0;
        repeat (2) @(negedge clk);
        cs_n = 1'b1; wr_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic reg_wr(input logic [7:0] addr, input logic [7:0] val);
        bus_wr(1'b0, addr);
        bus_wr(1'b1, val);
    endtask

    // One phi1 enable; outputs are sampled just before the enabled edge.
    task automatic phi1(output logic b, output logic fra, output logic frb);
        @(negedge clk);
        ncen_n = 1'b0;
        b = busy; fra = frst_a; frb = frst_b;
        @(negedge clk);
        ncen_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic drain();
        logic b, x, y;
        for (int i = 0; i < 100 && busy; i++) phi1(b, x, y);
        chk("drain_busy", busy, 0);
    endtask

    task automatic count_busy(input string tag);
        logic b, x, y;
        int   cnt;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            phi1(b, x, y);
            if (!b) break;
            cnt++;
        end
        chk(tag, cnt, 32);
    endtask

    initial begin
        logic b, x, y;
        int   ca, cb;

        repeat (3) @(negedge clk);
        chk("rst_regs", {clka1, clka2, clkb, run_a, run_b, irq_a, irq_b,
                         frst_a, frst_b, csm, test_d2, busy}, 0);
        chk("rst_rd", {o_d, o_d_oe}, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_rd", {o_d, o_d_oe}, 0);

        reg_wr(8'h10, 8'hA5);
        chk("clka1", clka1, 8'hA5);
        chk("busy_after_wr", busy, 1);
        reg_wr(8'h11, 8'hFF);
        chk("clka2", clka2, 2'b11);
        reg_wr(8'h12, 8'h3C);
        chk("clkb", clkb, 8'h3C);
        chk("clka1_kept", clka1, 8'hA5);
        bus_wr(1'b1, 8'h5A);
        chk("latch_persist", clkb, 8'h5A);
        reg_wr(8'h20, 8'hFF);
        chk("ignored_addr", {clka1, clka2, clkb}, {8'hA5, 2'b11, 8'h5A});
        reg_wr(8'h01, 8'hFB);
        chk("test_d2_0", test_d2, 0);
        reg_wr(8'h01, 8'h04);
        chk("test_d2_1", test_d2, 1);

        reg_wr(8'h14, 8'h8F);
        chk("ctl_8f", {csm, irq_b, irq_a, run_b, run_a}, 5'b11111);
        chk("frst_8f", {frst_a, frst_b}, 2'b00);
        reg_wr(8'h14, 8'h30);
        chk("frst_set", {frst_a, frst_b}, 2'b11);
        chk("ctl_30", {csm, irq_b, irq_a, run_b, run_a}, 5'b00000);
        ca = 0; cb = 0;
        for (int i = 0; i < 3; i++) begin
            phi1(b, x, y);
            ca += int'(x);
            cb += int'(y);
        end
        chk("frst_a_samples", ca, 1);
        chk("frst_b_samples", cb, 1);

        bus_wr(1'b0, 8'h20);
        drain();
        bus_wr(1'b1, 8'h00);
        count_busy("busy_len");
        chk("busy_end", busy, 0);
        bus_wr(1'b1, 8'h00);
        for (int i = 0; i < 10; i++) phi1(b, x, y);
        chk("busy_mid", busy, 1);
        bus_wr(1'b1, 8'h00);
        count_busy("busy_reload_len");

        fa = 1'b1; fb = 1'b0;
        bus_wr(1'b1, 8'h00);
        @(negedge clk);
        a0 = 1'b1; cs_n = 1'b0; rd_n = 1'b0;
        @(negedge clk);
        chk("rd_oe", o_d_oe, 1);
        chk("rd_status", o_d, 8'h81);
        cs_n = 1'b1; rd_n = 1'b1;
        @(negedge clk);
        chk("rd_oe_off", o_d_oe, 0);

        drain();
        reg_wr(8'h12, 8'h3C);
        drain();
        @(negedge clk);
        a0 = 1'b0; cs_n = 1'b0; rd_n = 1'b0;
        @(negedge clk);
`ifdef IKAOPM_TIMER_REGREAD_EN
        chk("rd_a0_0", o_d, 8'h3C);
`else
        chk("rd_a0_0", o_d, 8'h01);
`endif
        cs_n = 1'b1; rd_n = 1'b1;

        fa = 1'b0;
        @(negedge clk);
        a0 = 1'b1; d = 8'h77; cs_n = 1'b0; wr_n = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        cs_n = 1'b1; wr_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("mrst_regs", {clka1, clka2, clkb, run_a, run_b, irq_a, irq_b,
                          frst_a, frst_b, csm, test_d2, busy}, 0);
        chk("mrst_rd", {o_d, o_d_oe}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
